// File: rtl/pqsdn_flow_stat_upd.sv
// Per-flow statistics read-modify-write engine in front of an async-read RAM.
// Saturating packet/byte counters, write forwarding over the RAM's 2-cycle commit, table sweep, stat reads.
module pqsdn_flow_stat_upd #(
  parameter int ADDR_W = 10,
  parameter int PKT_W  = 32,
  parameter int BYTE_W = 32,
  parameter int LEN_W  = 16,
  localparam int DATA_W = PKT_W + BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  output logic              init_done_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_flow_i,
  input  logic [LEN_W-1:0]  in_len_i,
  input  logic              st_req_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic              st_clr_i,
  output logic              st_valid_o,
  output logic [DATA_W-1:0] st_data_o,
  output logic              en_a_o,
  output logic [ADDR_W-1:0] wraddr_a_o,
  output logic [DATA_W-1:0] wrdata_a_o,
  output logic              rden_b_o,
  output logic [ADDR_W-1:0] rdaddr_b_o,
  input  logic [DATA_W-1:0] rddata_i
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrEn_q, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic              fwdEn_q;
  logic [ADDR_W-1:0] fwdAddr_q;
  logic [DATA_W-1:0] fwdData_q;
  logic              stValid_q;
  logic [DATA_W-1:0] stData_q;

  logic              run;
  logic              stFire;
  logic              updFire;
  logic [DATA_W-1:0] oldWord;
  logic [PKT_W:0]    pktSum;
  logic [BYTE_W:0]   byteSum;
  logic [PKT_W-1:0]  newPkt;
  logic [BYTE_W-1:0] newByte;

  assign run         = (state_q == ST_RUN);
  assign init_done_o = run;
  assign in_ready_o  = run & ~st_req_i & ~clr_i;
  assign stFire      = run & st_req_i;
  assign updFire     = in_valid_i & in_ready_o;
  assign rden_b_o    = stFire | updFire;
  assign rdaddr_b_o  = stFire ? st_addr_i : (updFire ? in_flow_i : '0);

  // The newest in-flight write wins: the one on the RAM port, then the one inside the RAM's stage.
  always_comb begin
    if (wrEn_q && (wrAddr_q == rdaddr_b_o)) begin
      oldWord = wrData_q;
    end else if (fwdEn_q && (fwdAddr_q == rdaddr_b_o)) begin
      oldWord = fwdData_q;
    end else begin
      oldWord = rddata_i;
    end
  end

  assign pktSum  = {1'b0, oldWord[DATA_W-1:BYTE_W]} + {{PKT_W{1'b0}}, 1'b1};
  assign byteSum = {1'b0, oldWord[BYTE_W-1:0]} + {{(BYTE_W + 1 - LEN_W){1'b0}}, in_len_i};
  assign newPkt  = pktSum[PKT_W] ? '1 : pktSum[PKT_W-1:0];
  assign newByte = byteSum[BYTE_W] ? '1 : byteSum[BYTE_W-1:0];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wrEn_d   = 1'b0;
    wrAddr_d = '0;
    wrData_d = '0;
    case (state_q)
      ST_INIT: begin
        wrEn_d   = 1'b1;
        wrAddr_d = ptr_q;
        ptr_d    = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (ptr_q == PTR_LAST) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end
      end
      default: begin
        if (stFire && st_clr_i) begin
          wrEn_d   = 1'b1;
          wrAddr_d = st_addr_i;
        end else if (updFire) begin
          wrEn_d   = 1'b1;
          wrAddr_d = in_flow_i;
          wrData_d = {newPkt, newByte};
        end
        // The op accepted alongside clr_i is still written; the sweep's zeros follow it.
        if (clr_i) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      ptr_q     <= '0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      fwdEn_q   <= 1'b0;
      fwdAddr_q <= '0;
      fwdData_q <= '0;
      stValid_q <= 1'b0;
      stData_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      fwdEn_q   <= wrEn_q;
      fwdAddr_q <= wrAddr_q;
      fwdData_q <= wrData_q;
      stValid_q <= stFire;
      if (stFire) begin
        stData_q <= oldWord;
      end
    end
  end

  assign en_a_o     = wrEn_q;
  assign wraddr_a_o = wrAddr_q;
  assign wrdata_a_o = wrData_q;
  assign st_valid_o = stValid_q;
  assign st_data_o  = stData_q;

endmodule

// File: tb/tb_pqsdn_flow_stat_upd.sv
// Directed bench for pqsdn_flow_stat_upd with a behavioural async-read RAM that commits 2 clocks after en_a_o.
module tb_pqsdn_flow_stat_upd;

  localparam int ADDR_W = 4;
  localparam int PKT_W  = 8;
  localparam int BYTE_W = 16;
  localparam int LEN_W  = 8;
  localparam int DATA_W = PKT_W + BYTE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr_i = 1'b0;
  logic              init_done_o;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [ADDR_W-1:0] in_flow_i = '0;
  logic [LEN_W-1:0]  in_len_i = '0;
  logic              st_req_i = 1'b0;
  logic [ADDR_W-1:0] st_addr_i = '0;
  logic              st_clr_i = 1'b0;
  logic              st_valid_o;
  logic [DATA_W-1:0] st_data_o;
  logic              en_a_o;
  logic [ADDR_W-1:0] wraddr_a_o;
  logic [DATA_W-1:0] wrdata_a_o;
  logic              rden_b_o;
  logic [ADDR_W-1:0] rdaddr_b_o;
  logic [DATA_W-1:0] rddata_i;

  int checkCount = 0;
  int passCount  = 0;

  pqsdn_flow_stat_upd #(
    .ADDR_W(ADDR_W), .PKT_W(PKT_W), .BYTE_W(BYTE_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .clr_i(clr_i), .init_done_o(init_done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_flow_i(in_flow_i), .in_len_i(in_len_i),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_clr_i(st_clr_i),
    .st_valid_o(st_valid_o), .st_data_o(st_data_o),
    .en_a_o(en_a_o), .wraddr_a_o(wraddr_a_o), .wrdata_a_o(wrdata_a_o),
    .rden_b_o(rden_b_o), .rdaddr_b_o(rdaddr_b_o), .rddata_i(rddata_i)
  );

  always #5 clk = ~clk;

  // RAM model: one internal stage between the write port and the array; preload port is bench-only.
  logic [DATA_W-1:0] mem [16];
  logic              stgEn = 1'b0;
  logic [ADDR_W-1:0] stgAddr = '0;
  logic [DATA_W-1:0] stgData = '0;
  logic              preEn = 1'b0;
  logic [ADDR_W-1:0] preAddr = '0;
  logic [DATA_W-1:0] preData = '0;

  always @(posedge clk) begin
    stgEn   <= en_a_o;
    stgAddr <= wraddr_a_o;
    stgData <= wrdata_a_o;
    if (stgEn) mem[stgAddr] <= stgData;
    if (preEn) mem[preAddr] <= preData;
  end

  assign rddata_i = mem[rdaddr_b_o];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Inputs change on the falling edge; the #1 lets combinational outputs settle before checks.
  task automatic applyStimulus(input logic valid, input logic [ADDR_W-1:0] flow, input logic [LEN_W-1:0] len,
                               input logic stReq, input logic [ADDR_W-1:0] stAddr, input logic stClr,
                               input logic clr);
    @(negedge clk);
    in_valid_i = valid;
    in_flow_i  = flow;
    in_len_i   = len;
    st_req_i   = stReq;
    st_addr_i  = stAddr;
    st_clr_i   = stClr;
    clr_i      = clr;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic statRead(input string tag, input logic [ADDR_W-1:0] addr, input logic clrOnRead,
                          input logic [DATA_W-1:0] expected);
    applyStimulus(1'b0, '0, '0, 1'b1, addr, clrOnRead, 1'b0);
    idleCycle();
    checkOutput({tag, "_valid"}, {31'd0, st_valid_o}, 32'd1);
    checkOutput({tag, "_data"}, {8'd0, st_data_o}, {8'd0, expected});
  endtask

  task automatic waitInit(input string tag);
    int initCycles = 0;
    int zeroWrites = 0;
    int badWrites  = 0;
    int readyHigh  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_valid_i = 1'b0;
      st_req_i   = 1'b0;
      st_clr_i   = 1'b0;
      clr_i      = 1'b0;
      #1;
      if (en_a_o) begin
        if (wraddr_a_o != zeroWrites[ADDR_W-1:0] || wrdata_a_o != '0) badWrites++;
        zeroWrites++;
      end
      if (init_done_o) break;
      initCycles++;
      if (in_ready_o) readyHigh++;
    end
    checkOutput({tag, "_init_cycles"}, initCycles, 32'd16);
    checkOutput({tag, "_zero_writes"}, zeroWrites, 32'd16);
    checkOutput({tag, "_write_seq"}, badWrites, 32'd0);
    checkOutput({tag, "_ready_low"}, readyHigh, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_init_done", {31'd0, init_done_o}, 32'd0);
    checkOutput("rst_en_a", {31'd0, en_a_o}, 32'd0);
    checkOutput("rst_st_valid", {31'd0, st_valid_o}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitInit("sweep1");

    statRead("st7_after_init", 4'd7, 1'b0, 24'h000000);

    applyStimulus(1'b1, 4'd3, 8'd100, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("upd3a_ready", {31'd0, in_ready_o}, 32'd1);
    checkOutput("upd3a_rdaddr", {28'd0, rdaddr_b_o}, 32'd3);
    applyStimulus(1'b1, 4'd3, 8'd50, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("upd3a_wraddr", {28'd0, wraddr_a_o}, 32'd3);
    checkOutput("upd3a_wrdata", {8'd0, wrdata_a_o}, 32'h010064);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, 1'b0, 1'b0);
    checkOutput("upd3b_wrdata", {8'd0, wrdata_a_o}, 32'h020096);
    idleCycle();
    checkOutput("st3_fwd_valid", {31'd0, st_valid_o}, 32'd1);
    checkOutput("st3_fwd_data", {8'd0, st_data_o}, 32'h020096);

    // Flow 5 updates with gaps 0, 1, 2 and back-to-back again.
    applyStimulus(1'b1, 4'd5, 8'd1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 8'd1, 1'b0, '0, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(1'b1, 4'd5, 8'd1, 1'b0, '0, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    applyStimulus(1'b1, 4'd5, 8'd1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 8'd1, 1'b0, '0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("flow5_final_wr", {8'd0, wrdata_a_o}, 32'h050005);
    repeat (3) idleCycle();
    statRead("st5", 4'd5, 1'b0, 24'h050005);

    @(negedge clk);
    preEn = 1'b1; preAddr = 4'd9; preData = 24'hFEFFF0;
    @(negedge clk);
    preEn = 1'b0;
    idleCycle();
    applyStimulus(1'b1, 4'd9, 8'h20, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd9, 8'h20, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("sat_first", {8'd0, wrdata_a_o}, 32'hFFFFFF);
    idleCycle();
    checkOutput("sat_hold", {8'd0, wrdata_a_o}, 32'hFFFFFF);

    // Stat read with clear wins the read port; the flow 6 update waits one cycle.
    applyStimulus(1'b1, 4'd6, 8'd7, 1'b1, 4'd3, 1'b1, 1'b0);
    checkOutput("arb_ready_low", {31'd0, in_ready_o}, 32'd0);
    checkOutput("arb_rdaddr", {28'd0, rdaddr_b_o}, 32'd3);
    applyStimulus(1'b1, 4'd6, 8'd7, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("arb_ready_high", {31'd0, in_ready_o}, 32'd1);
    checkOutput("clr_read_data", {8'd0, st_data_o}, 32'h020096);
    checkOutput("clr_write_addr", {28'd0, wraddr_a_o}, 32'd3);
    checkOutput("clr_write_data", {8'd0, wrdata_a_o}, 32'h000000);
    idleCycle();
    checkOutput("held_upd_addr", {28'd0, wraddr_a_o}, 32'd6);
    checkOutput("held_upd_data", {8'd0, wrdata_a_o}, 32'h010007);
    statRead("st3_cleared", 4'd3, 1'b0, 24'h000000);
    statRead("st6", 4'd6, 1'b0, 24'h010007);

    applyStimulus(1'b1, 4'd1, 8'd5, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd2, 8'd6, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr_ready_low", {31'd0, in_ready_o}, 32'd0);
    waitInit("sweep2");
    in_valid_i = 1'b1;
    in_flow_i  = 4'd1;
    in_len_i   = 8'd9;
    #1;
    checkOutput("post_clr_ready", {31'd0, in_ready_o}, 32'd1);
    idleCycle();
    checkOutput("post_clr_flow1", {8'd0, wrdata_a_o}, 32'h010009);
    statRead("st2_after_clr", 4'd2, 1'b0, 24'h000000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
